// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN frame sequencer.
package snn_ctrl_pkg;

    // Sequencer states; every state except S_RECV counts as busy.
    typedef enum logic [2:0] {
        S_RECV,
        S_START,
        S_COMPUTE,
        S_TX_DIG,
        S_TX_CR,
        S_TX_LF
    } state_t;

    localparam int DEF_FRAME_BYTES = 98;        // 784 pixels, 8 per byte
    localparam int DEF_GAP_TIMEOUT = 1_000_000; // 20 ms at 50 MHz

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Digits 0..9 map to '0'..'9'; anything larger is reported as '?'.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return (digit <= 4'd9) ? (ASCII_ZERO + {4'b0000, digit}) : ASCII_QMARK;
    endfunction

endpackage

// File: rtl/snn_frame_ctrl_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags expiry.
module gap_timer #(
    parameter int GAP_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int             CW      = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT   = CW'(GAP_TIMEOUT);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [CW-1:0] cnt;

    // Saturating idle counter; restarts on every accepted byte or when disabled.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // High for the single cycle the limit is reached; the owner then disables us.
    assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/snn_frame_ctrl.sv
// Frame sequencer: UART bytes -> loader -> SNN core -> ASCII report on UART.
module snn_frame_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT,
    parameter bit SEND_CRLF   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       load_en,
    output logic [7:0] load_data,
    output logic       loader_clr,
    output logic       core_start,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_rdy,
    output logic       busy,
    output logic [7:0] led
);

    localparam int               CNT_W     = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [3:0]       last_digit;
    logic             guard;
    logic             to_flag;
    logic             ov_flag;
    logic             accept;
    logic             gap_en;
    logic             gap_expire;

    assign accept    = rx_rdy && (state == S_RECV);
    assign load_en   = accept;
    assign load_data = rx_data;
    assign busy      = (state != S_RECV);
    assign led       = {ov_flag, to_flag, busy, 1'b0, last_digit};
    assign gap_en    = (state == S_RECV) && (byte_cnt != '0);

    // The transmit strobe follows tx_rdy in the same cycle so the digit can go
    // out the cycle after core_done; guard blocks the cycle after each pulse.
    assign tx_start = (state inside {S_TX_DIG, S_TX_CR, S_TX_LF}) && tx_rdy && !guard;

    gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (gap_en),
        .clr    (accept),
        .expire (gap_expire)
    );

    // Main sequencer: byte counting, core handshake, report transmission, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RECV;
            byte_cnt   <= '0;
            last_digit <= '0;
            guard      <= 1'b0;
            to_flag    <= 1'b0;
            ov_flag    <= 1'b0;
            core_start <= 1'b0;
            loader_clr <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            core_start <= 1'b0;
            loader_clr <= 1'b0;
            guard      <= 1'b0;

            if (rx_rdy && busy) begin
                ov_flag <= 1'b1;
            end

            case (state)
                S_RECV: begin
                    if (rx_rdy) begin
                        // A received byte always beats a coincident gap expiry.
                        if (byte_cnt == '0) begin
                            ov_flag <= 1'b0;
                            to_flag <= 1'b0;
                        end
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt   <= '0;
                            core_start <= 1'b1;
                            state      <= S_START;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_ONE;
                        end
                    end else if (gap_expire) begin
                        byte_cnt   <= '0;
                        loader_clr <= 1'b1;
                        to_flag    <= 1'b1;
                    end
                end
                S_START: begin
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (core_done) begin
                        last_digit <= core_digit;
                        tx_data    <= digit_to_ascii(core_digit);
                        state      <= S_TX_DIG;
                    end
                end
                S_TX_DIG: begin
                    if (tx_start) begin
                        guard <= 1'b1;
                        if (SEND_CRLF) begin
                            tx_data <= ASCII_CR;
                            state   <= S_TX_CR;
                        end else begin
                            state <= S_RECV;
                        end
                    end
                end
                S_TX_CR: begin
                    if (tx_start) begin
                        guard   <= 1'b1;
                        tx_data <= ASCII_LF;
                        state   <= S_TX_LF;
                    end
                end
                S_TX_LF: begin
                    if (tx_start) begin
                        guard <= 1'b1;
                        state <= S_RECV;
                    end
                end
                default: state <= S_RECV;
            endcase
        end
    end

endmodule
